// File: rtl/dmem_ctrl_pkg.sv
// ---------------------------------------------------------------------------
// dmem_ctrl_pkg
//   Shared definitions for the data-memory access controller:
//   - state_e      : controller FSM states
//   - F3_*         : funct[2:0] width/extension codes
//   - MC_*         : bit positions inside the EX/MEM mem_ctrl field
//   - is_misaligned: alignment rule for halfword/word accesses
// ---------------------------------------------------------------------------
package dmem_ctrl_pkg;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    ACCESS = 2'd1,
    DONE   = 2'd2
  } state_e;

  localparam logic [2:0] F3_B  = 3'b000;
  localparam logic [2:0] F3_H  = 3'b001;
  localparam logic [2:0] F3_W  = 3'b010;
  localparam logic [2:0] F3_BU = 3'b100;
  localparam logic [2:0] F3_HU = 3'b101;

  localparam int MC_READ   = 0;
  localparam int MC_WRITE  = 1;
  localparam int MC_BRANCH = 2;

  // Halfwords need an even address, words a multiple of four.  Byte accesses
  // and undefined codes are never flagged.
  function automatic logic is_misaligned(input logic [2:0] f3, input logic [1:0] off);
    logic is_half;
    is_half = (f3 == F3_H) || (f3 == F3_HU);
    return (is_half && off[0]) || ((f3 == F3_W) && (off != 2'b00));
  endfunction

endpackage

// File: rtl/load_extend.sv
// ---------------------------------------------------------------------------
// load_extend
//   Selects the addressed byte/halfword lane of a 32-bit memory word and
//   sign- or zero-extends it according to funct[2:0].
// Ports
//   i_rdata    in  32  raw word returned by the data memory
//   i_byte_off in  2   byte offset of the original access (addr[1:0])
//   i_funct3   in  3   width/extension code (B, H, W, BU, HU)
//   o_data     out 32  extended load result
// ---------------------------------------------------------------------------
module load_extend
  import dmem_ctrl_pkg::*;
(
  input  logic [31:0] i_rdata,
  input  logic [1:0]  i_byte_off,
  input  logic [2:0]  i_funct3,
  output logic [31:0] o_data
);

  logic [31:0] w_lane;

  // Shift the addressed lane down to bit 0.
  assign w_lane = i_rdata >> {i_byte_off, 3'b000};

  always_comb begin
    // NOTE: every always_comb output gets a default first so no path leaves
    // it unassigned and no latch is inferred.
    o_data = i_rdata;
    case (i_funct3)
      F3_B:    o_data = {{24{w_lane[7]}}, w_lane[7:0]};
      F3_H:    o_data = {{16{w_lane[15]}}, w_lane[15:0]};
      F3_BU:   o_data = {24'b0, w_lane[7:0]};
      F3_HU:   o_data = {16'b0, w_lane[15:0]};
      default: o_data = i_rdata;  // W and undefined codes return the full word
    endcase
  end

endmodule

// File: rtl/dmem_access_ctrl.sv
// ---------------------------------------------------------------------------
// dmem_access_ctrl
//   Sequences the data-memory access of the instruction sitting in EX/MEM.
//   IDLE decodes the op and latches the request; ACCESS holds dmem_req until
//   the memory answers or the wait limit expires; DONE releases the stall for
//   one cycle so the instruction can leave EX/MEM.
// Ports
//   clk, rst     clock, synchronous active-high reset
//   mem_ctrl     [0]=MemRead [1]=MemWrite [2]=Branch (unused here)
//   addr         byte address (EX/MEM ALU result)
//   wrt_data     store data
//   funct        [2:0] access width / extension code
//   dmem_req     request, held until ready or timeout
//   dmem_we      1=write, 0=read
//   dmem_addr    word-aligned address
//   dmem_wdata   store data replicated across lanes
//   dmem_be      byte enables
//   dmem_ready   memory accepts/completes this cycle
//   dmem_rdata   read data, valid with dmem_ready
//   rd_data      extended load result (registered)
//   mem_stall    hold PC, IF/ID, ID/EX, EX/MEM
//   wb_bubble    zero MEM/WB write-back controls this cycle
//   misalign     one-cycle pulse: misaligned access dropped
//   timeout      one-cycle pulse: access abandoned
// ---------------------------------------------------------------------------
module dmem_access_ctrl
  import dmem_ctrl_pkg::*;
#(
  parameter int DATA_WIDTH = 32,
  parameter int TIMEOUT    = 15
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic [2:0]              mem_ctrl,
  input  logic [DATA_WIDTH-1:0]   addr,
  input  logic [DATA_WIDTH-1:0]   wrt_data,
  input  logic [3:0]              funct,
  output logic                    dmem_req,
  output logic                    dmem_we,
  output logic [DATA_WIDTH-1:0]   dmem_addr,
  output logic [DATA_WIDTH-1:0]   dmem_wdata,
  output logic [DATA_WIDTH/8-1:0] dmem_be,
  input  logic                    dmem_ready,
  input  logic [DATA_WIDTH-1:0]   dmem_rdata,
  output logic [DATA_WIDTH-1:0]   rd_data,
  output logic                    mem_stall,
  output logic                    wb_bubble,
  output logic                    misalign,
  output logic                    timeout
);

  generate
    if (DATA_WIDTH != 32) begin : g_bad_width
      $error("dmem_access_ctrl: DATA_WIDTH must be 32");
    end
  endgenerate

  localparam int CNT_W = (TIMEOUT > 1) ? $clog2(TIMEOUT) : 1;

  state_e                    r_state;
  logic                      r_req;
  logic                      r_we;
  logic [DATA_WIDTH-1:0]     r_addr;
  logic [DATA_WIDTH-1:0]     r_wdata;
  logic [DATA_WIDTH/8-1:0]   r_be;
  logic [DATA_WIDTH-1:0]     r_rd_data;
  logic                      r_misalign;
  logic                      r_timeout;
  logic                      r_to_flag;
  logic [CNT_W-1:0]          r_cnt;
  logic [1:0]                r_byte_off;
  logic [2:0]                r_funct3;

  logic                      w_is_read;
  logic                      w_is_write;
  logic                      w_op;
  logic [2:0]                w_funct3;
  logic                      w_misaligned;
  logic                      w_start;
  logic [DATA_WIDTH/8-1:0]   w_be;
  logic [DATA_WIDTH-1:0]     w_wdata;
  logic [DATA_WIDTH-1:0]     w_load_ext;
  logic                      w_unused;

  assign w_is_read    = mem_ctrl[MC_READ];
  assign w_is_write   = mem_ctrl[MC_WRITE];
  assign w_op         = w_is_read | w_is_write;
  assign w_funct3     = funct[2:0];
  assign w_misaligned = is_misaligned(w_funct3, addr[1:0]);
  assign w_start      = (r_state == IDLE) && w_op && !w_misaligned;
  assign w_unused     = ^{mem_ctrl[MC_BRANCH], funct[3]};

  // Store lane steering: only funct[1:0] matters for stores; anything that
  // is not a byte or halfword store is written as a full word.
  always_comb begin
    w_be    = '1;
    w_wdata = wrt_data;
    case (w_funct3[1:0])
      2'b00: begin
        w_be    = 4'b0001 << addr[1:0];
        w_wdata = {4{wrt_data[7:0]}};
      end
      2'b01: begin
        w_be    = addr[1] ? 4'b1100 : 4'b0011;
        w_wdata = {2{wrt_data[15:0]}};
      end
      default: ;
    endcase
  end

  // Extension uses the offset/code captured at issue, not the live inputs.
  load_extend u_load_extend (
    .i_rdata    (dmem_rdata),
    .i_byte_off (r_byte_off),
    .i_funct3   (r_funct3),
    .o_data     (w_load_ext)
  );

  // NOTE: state is updated with non-blocking assignments only, so every
  // register samples pre-edge values regardless of statement order.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_state    <= IDLE;
      r_req      <= 1'b0;
      r_we       <= 1'b0;
      r_addr     <= '0;
      r_wdata    <= '0;
      r_be       <= '0;
      r_rd_data  <= '0;
      r_misalign <= 1'b0;
      r_timeout  <= 1'b0;
      r_to_flag  <= 1'b0;
      r_cnt      <= '0;
      r_byte_off <= '0;
      r_funct3   <= '0;
    end else begin
      // Pulses default low and are raised for exactly one cycle below.
      r_misalign <= 1'b0;
      r_timeout  <= 1'b0;
      case (r_state)
        IDLE: begin
          if (w_op) begin
            if (w_misaligned) begin
              r_misalign <= 1'b1;
            end else begin
              r_req      <= 1'b1;
              r_we       <= w_is_write;  // write wins when both bits are set
              r_addr     <= {addr[DATA_WIDTH-1:2], 2'b00};
              r_be       <= w_be;
              r_wdata    <= w_wdata;
              r_byte_off <= addr[1:0];
              r_funct3   <= w_funct3;
              r_cnt      <= '0;
              r_state    <= ACCESS;
            end
          end
        end
        ACCESS: begin
          if (dmem_ready) begin
            // Ready on the limit cycle still wins over the timeout.
            r_rd_data <= r_we ? '0 : w_load_ext;
            r_req     <= 1'b0;
            r_state   <= DONE;
          end else if (r_cnt == CNT_W'(TIMEOUT - 1)) begin
            r_req     <= 1'b0;
            r_timeout <= 1'b1;
            r_rd_data <= '0;
            r_to_flag <= 1'b1;
            r_state   <= DONE;
          end else begin
            r_cnt <= r_cnt + 1'b1;
          end
        end
        DONE: begin
          // The EX/MEM instruction leaves on this edge; no re-trigger.
          r_to_flag <= 1'b0;
          r_state   <= IDLE;
        end
        default: r_state <= IDLE;
      endcase
    end
  end

  // Stall/bubble must act in the same cycle the op is seen, so they stay
  // combinational on the state and decode.
  assign mem_stall = w_start || (r_state == ACCESS);
  assign wb_bubble = ((r_state == IDLE) && w_op) || (r_state == ACCESS) ||
                     ((r_state == DONE) && r_to_flag);

  assign dmem_req   = r_req;
  assign dmem_we    = r_we;
  assign dmem_addr  = r_addr;
  assign dmem_wdata = r_wdata;
  assign dmem_be    = r_be;
  assign rd_data    = r_rd_data;
  assign misalign   = r_misalign;
  assign timeout    = r_timeout;

endmodule

// File: tb/tb_dmem_access_ctrl.sv
// ---------------------------------------------------------------------------
// tb_dmem_access_ctrl
//   Directed and random transactions against dmem_access_ctrl.  The bench
//   acts as the data memory (a 16-word array) and derives every expected
//   value from the access rules with plain arithmetic.
// ---------------------------------------------------------------------------
module tb_dmem_access_ctrl;

  localparam int TIMEOUT = 15;

  logic        clk = 1'b0;
  logic        rst;
  logic [2:0]  mem_ctrl;
  logic [31:0] addr;
  logic [31:0] wrt_data;
  logic [3:0]  funct;
  logic        dmem_req;
  logic        dmem_we;
  logic [31:0] dmem_addr;
  logic [31:0] dmem_wdata;
  logic [3:0]  dmem_be;
  logic        dmem_ready;
  logic [31:0] dmem_rdata;
  logic [31:0] rd_data;
  logic        mem_stall;
  logic        wb_bubble;
  logic        misalign;
  logic        timeout;

  int checks = 0;
  int errors = 0;

  logic [31:0] mem [16];

  always #5 clk = ~clk;

  dmem_access_ctrl #(.DATA_WIDTH(32), .TIMEOUT(TIMEOUT)) dut (
    .clk        (clk),
    .rst        (rst),
    .mem_ctrl   (mem_ctrl),
    .addr       (addr),
    .wrt_data   (wrt_data),
    .funct      (funct),
    .dmem_req   (dmem_req),
    .dmem_we    (dmem_we),
    .dmem_addr  (dmem_addr),
    .dmem_wdata (dmem_wdata),
    .dmem_be    (dmem_be),
    .dmem_ready (dmem_ready),
    .dmem_rdata (dmem_rdata),
    .rd_data    (rd_data),
    .mem_stall  (mem_stall),
    .wb_bubble  (wb_bubble),
    .misalign   (misalign),
    .timeout    (timeout)
  );

  initial begin
    #200000;
    $display("FAIL watchdog: observed=no finish expected=finish");
    $fatal(1, "watchdog expired");
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed=%08h expected=%08h", tag, obs, exp);
    end
  endtask

  // Inputs change 1 time unit after a rising edge; outputs are read on the
  // falling edge.
  task automatic next_cycle();
    @(posedge clk);
    #1;
  endtask

  task automatic sample();
    @(negedge clk);
  endtask

  // ---- reference rules ----------------------------------------------------
  function automatic logic [31:0] exp_load(input logic [31:0] word, input int off,
                                           input logic [2:0] f3);
    longint lane;
    longint v;
    lane = longint'(word) / (longint'(1) << (8 * off));
    case (f3)
      3'd0: begin v = lane % 256;   if (v >= 128)   v -= 256;   return 32'(v); end
      3'd1: begin v = lane % 65536; if (v >= 32768) v -= 65536; return 32'(v); end
      3'd4: return 32'(lane % 256);
      3'd5: return 32'(lane % 65536);
      default: return word;
    endcase
  endfunction

  function automatic logic [3:0] exp_be(input int off, input logic [2:0] f3);
    case (f3[1:0])
      2'd0:    return 4'(1 << off);
      2'd1:    return (off >= 2) ? 4'd12 : 4'd3;
      default: return 4'd15;
    endcase
  endfunction

  function automatic logic [31:0] exp_wdata(input logic [31:0] wd, input logic [2:0] f3);
    case (f3[1:0])
      2'd0:    return (wd % 256) * 32'h0101_0101;
      2'd1:    return (wd % 65536) * 32'h0001_0001;
      default: return wd;
    endcase
  endfunction

  function automatic bit exp_misaligned(input int off, input logic [2:0] f3);
    return (((f3 == 3'd1) || (f3 == 3'd5)) && (off % 2 != 0)) ||
           ((f3 == 3'd2) && (off != 0));
  endfunction

  // One EX/MEM instruction.  waits = idle ACCESS cycles before ready; any
  // value >= TIMEOUT means the memory never answers.  Starts and ends just
  // after a rising edge.
  task automatic run_txn(input string name, input bit rd, input bit wr,
                         input logic [31:0] a, input logic [31:0] wd,
                         input logic [2:0] f3, input int waits);
    int          off;
    int          idx;
    int          n;
    int          stalls;
    bit          op;
    bit          mis;
    bit          done;
    bit          timed;
    bit          ready;
    logic [3:0]  be_e;
    logic [31:0] wd_e;
    logic [31:0] rd_e;

    off  = int'(a % 4);
    idx  = int'((a / 4) % 16);
    op   = rd | wr;
    mis  = op && exp_misaligned(off, f3);
    be_e = exp_be(off, f3);
    wd_e = exp_wdata(wd, f3);

    mem_ctrl   = {1'($urandom_range(0, 1)), wr, rd};
    addr       = a;
    wrt_data   = wd;
    funct      = {1'($urandom_range(0, 1)), f3};
    dmem_ready = 1'b0;
    sample();
    check({name, " idle stall"},  mem_stall, op && !mis);
    check({name, " idle bubble"}, wb_bubble, op);
    check({name, " idle req"},    dmem_req,  0);
    stalls = mem_stall ? 1 : 0;

    if (!op) begin
      next_cycle();
      return;
    end

    if (mis) begin
      next_cycle();
      mem_ctrl = 3'b000;
      sample();
      check({name, " misalign pulse"},  misalign,  1);
      check({name, " misalign req"},    dmem_req,  0);
      check({name, " misalign stall"},  mem_stall, 0);
      check({name, " misalign bubble"}, wb_bubble, 0);
      next_cycle();
      sample();
      check({name, " misalign end"}, misalign, 0);
      next_cycle();
      return;
    end

    rd_e  = (wr) ? 32'd0 : exp_load(mem[idx], off, f3);
    done  = 1'b0;
    timed = 1'b0;
    n     = 0;
    while (!done) begin
      next_cycle();
      ready      = (n == waits);
      dmem_ready = ready;
      dmem_rdata = (ready && !wr) ? mem[idx] : $urandom;
      sample();
      check({name, " access req"},    dmem_req,  1);
      check({name, " access stall"},  mem_stall, 1);
      check({name, " access bubble"}, wb_bubble, 1);
      if (n == 0) begin
        check({name, " we"},   dmem_we,   wr);
        check({name, " addr"}, dmem_addr, a - 32'(off));
        if (wr) begin
          check({name, " be"},    dmem_be,    be_e);
          check({name, " wdata"}, dmem_wdata, wd_e);
        end
      end
      if (mem_stall) stalls++;
      if (ready) begin
        done = 1'b1;
        if (wr) begin
          for (int i = 0; i < 4; i++)
            if (be_e[i]) mem[idx][8*i +: 8] = wd_e[8*i +: 8];
        end
      end else if (n == TIMEOUT - 1) begin
        done  = 1'b1;
        timed = 1'b1;
      end
      n++;
    end

    next_cycle();
    dmem_ready = 1'b0;
    sample();
    check({name, " done req"},     dmem_req,  0);
    check({name, " done stall"},   mem_stall, 0);
    check({name, " done bubble"},  wb_bubble, timed);
    check({name, " done timeout"}, timeout,   timed);
    check({name, " rd_data"},      rd_data,   timed ? 32'd0 : rd_e);
    check({name, " stall cycles"}, stalls,    timed ? TIMEOUT + 1 : waits + 2);

    next_cycle();
    mem_ctrl = 3'b000;
    sample();
    check({name, " back idle stall"}, mem_stall, 0);
    check({name, " timeout end"},     timeout,   0);
    next_cycle();
  endtask

  initial begin
    logic [2:0] rd_codes [5];
    int         kind;
    int         waits;
    logic [2:0] f3;
    bit         pulse_seen;
    bit         req_seen;

    rd_codes[0] = 3'd0; rd_codes[1] = 3'd1; rd_codes[2] = 3'd2;
    rd_codes[3] = 3'd4; rd_codes[4] = 3'd5;
    for (int i = 0; i < 16; i++) mem[i] = $urandom;

    rst        = 1'b1;
    mem_ctrl   = 3'b000;
    addr       = '0;
    wrt_data   = '0;
    funct      = '0;
    dmem_ready = 1'b0;
    dmem_rdata = '0;
    next_cycle();
    next_cycle();
    sample();
    check("reset req",      dmem_req,   0);
    check("reset we",       dmem_we,    0);
    check("reset addr",     dmem_addr,  0);
    check("reset wdata",    dmem_wdata, 0);
    check("reset be",       dmem_be,    0);
    check("reset rd_data",  rd_data,    0);
    check("reset misalign", misalign,   0);
    check("reset timeout",  timeout,    0);
    check("reset stall",    mem_stall,  0);
    next_cycle();
    rst = 1'b0;
    sample();
    check("idle stall", mem_stall, 0);
    next_cycle();

    mem[1] = 32'hDEAD_BEEF;
    run_txn("lw_0x104", 1, 0, 32'h104, 32'h0, 3'd2, 0);
    mem[0] = 32'h8000_0000;
    run_txn("lb_0x103",  1, 0, 32'h103, 32'h0, 3'd0, 0);
    run_txn("lbu_0x103", 1, 0, 32'h103, 32'h0, 3'd4, 2);
    run_txn("sh_0x102",  0, 1, 32'h102, 32'h1234_ABCD, 3'd1, 4);
    run_txn("lh_0x102",  1, 0, 32'h102, 32'h0, 3'd1, 1);
    run_txn("lw_0x101",  1, 0, 32'h101, 32'h0, 3'd2, 0);
    run_txn("lw_never",  1, 0, 32'h108, 32'h0, 3'd2, TIMEOUT);
    run_txn("sb_both",   1, 1, 32'h111, 32'h0000_005A, 3'd0, 1);
    run_txn("lw_merge",  1, 0, 32'h110, 32'h0, 3'd2, 0);
    mem[3] = 32'h1357_9BDF;
    run_txn("lw_limit",  1, 0, 32'h10C, 32'h0, 3'd2, TIMEOUT - 1);

    // Reset during the third ACCESS cycle.
    mem_ctrl = 3'b001;
    addr     = 32'h118;
    funct    = 4'd2;
    sample();
    for (int i = 0; i < 3; i++) begin
      next_cycle();
      if (i == 2) begin
        rst      = 1'b1;
        mem_ctrl = 3'b000;
      end
      sample();
      check("rst pre req", dmem_req, 1);
    end
    next_cycle();
    rst = 1'b0;
    sample();
    check("rst req",     dmem_req,  0);
    check("rst stall",   mem_stall, 0);
    check("rst bubble",  wb_bubble, 0);
    check("rst rd_data", rd_data,   0);
    check("rst addr",    dmem_addr, 0);
    pulse_seen = 1'b0;
    req_seen   = 1'b0;
    for (int i = 0; i < TIMEOUT + 2; i++) begin
      next_cycle();
      sample();
      pulse_seen |= timeout;
      req_seen   |= dmem_req;
    end
    check("rst no timeout", pulse_seen, 0);
    check("rst no req",     req_seen,   0);
    next_cycle();

    for (int t = 0; t < 60; t++) begin
      kind  = $urandom_range(0, 3);
      waits = ($urandom_range(0, 9) == 0) ? TIMEOUT + $urandom_range(0, 3)
                                          : $urandom_range(0, 5);
      if (kind >= 2) f3 = 3'($urandom_range(0, 2));
      else           f3 = rd_codes[$urandom_range(0, 4)];
      run_txn($sformatf("rnd%0d", t), (kind == 1) || (kind == 3), kind >= 2,
              32'h100 + 32'($urandom_range(0, 63)), $urandom, f3, waits);
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
